instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 126 ++++++++++++
 tb/tb_instr_mem_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Streams a big-endian word count plus 4-byte words into instruction memory writes.
// Optional trailer checksum byte (XOR of all data bytes) enabled by LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {
        IDLE, HDR_HI, HDR_LO, DATA, WRITE, CHK, DONE, ERR
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] n_q, k_q;
    logic [1:0]  bcnt_q;
    logic [23:0] sh_q;
    logic [31:0] wr_addr_q, wr_data_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    logic        take, last_word, launch, n_bad;
    logic [15:0] n_full;

    assign take      = byte_valid & byte_ready;
    assign launch    = start & (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign n_full    = {n_q[15:8], byte_in};
    assign n_bad     = (n_full == 16'd0) || ({16'd0, n_full} > 32'(MAX_WORDS));
    assign last_word = (k_q == n_q - 16'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: if (start) state_d = HDR_HI;
            HDR_HI: if (take) state_d = HDR_LO;
            HDR_LO: if (take) state_d = n_bad ? ERR : DATA;
            DATA:   if (take && bcnt_q == 2'd3) state_d = WRITE;
`ifdef LOADER_CHECKSUM_EN
            WRITE:  state_d = last_word ? CHK : DATA;
            CHK:    if (take) state_d = (byte_in == csum_q) ? DONE : ERR;
`else
            WRITE:  state_d = last_word ? DONE : DATA;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        wr_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state_q)
            HDR_HI, HDR_LO, DATA, CHK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            WRITE: begin
                wr_en = 1'b1;
                busy  = 1'b1;
            end
            DONE:    done  = 1'b1;
            ERR:     error = 1'b1;
            default: ;
        endcase
    end

    // Write address/data are latched on the 4th byte so they stay stable outside WRITE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q       <= '0;
            k_q       <= '0;
            bcnt_q    <= '0;
            sh_q      <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else if (launch) begin
            k_q    <= '0;
            bcnt_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else begin
            case (state_q)
                HDR_HI: if (take) n_q[15:8] <= byte_in;
                HDR_LO: if (take) n_q[7:0]  <= byte_in;
                DATA: if (take) begin
                    bcnt_q <= bcnt_q + 2'd1;
                    sh_q   <= {sh_q[15:0], byte_in};
`ifdef LOADER_CHECKSUM_EN
                    csum_q <= csum_q ^ byte_in;
`endif
                    if (bcnt_q == 2'd3) begin
                        wr_data_q <= {sh_q, byte_in};
                        wr_addr_q <= BASE_ADDR + {14'd0, k_q, 2'b00};
                    end
                end
                WRITE: if (!last_word) k_q <= k_q + 16'd1;
                default: ;
            endcase
        end
    end

    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: expected writes are queued as stimulus is driven
// and popped by a write monitor. Checksum trailer steps follow LOADER_CHECKSUM_EN.
module tb_instr_mem_loader;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready, wr_en, busy, done, error;
    logic [31:0] wr_addr, wr_data;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_q[$];
    logic [31:0] words[256];

    instr_mem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(64)) dut (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && wr_en) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_wr observed=%h:%h expected=none", wr_addr, wr_data);
            end else begin
                chk("wr_addr_data", {wr_addr, wr_data}, exp_q.pop_front());
            end
            chk("ready_during_wr", 64'(byte_ready), 64'd0);
        end
    end

    task automatic send(input logic [7:0] b, input bit gap);
        int bound = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && bound < 100) begin
            tick();
            bound++;
        end
        if (bound >= 100) chk("ready_timeout", 64'(bound), 64'd0);
        tick();
        byte_valid = 1'b0;
        if (gap) tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end();
        int bound = 0;
        while (!(done || error) && bound < 2000) begin
            tick();
            bound++;
        end
        if (bound >= 2000) chk("end_timeout", 64'(bound), 64'd0);
    endtask

    // Assumes start already issued; poke>=0 pulses start before that data byte index.
    task automatic load(input int n, input bit gap, input bit good_ck, input int poke);
        logic [7:0]  ck;
        logic [15:0] n16;
        logic [7:0]  b;
        ck  = 8'h00;
        n16 = 16'(n);
        for (int i = 0; i < n; i++) exp_q.push_back({BASE + 32'(4 * i), words[i]});
        send(n16[15:8], gap);
        send(n16[7:0], gap);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (i * 4 + j == poke) begin
                    do_start();
                    chk("busy_after_poke", 64'({busy, done, error}), 64'b100);
                end
                b  = words[i][31 - 8 * j -: 8];
                ck = ck ^ b;
                send(b, gap);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send(good_ck ? ck : 8'h00 ^ (ck == 8'h00 ? 8'h01 : 8'h00), gap);
`endif
        wait_end();
        chk("done_error", 64'({done, error}), good_ck ? 64'b10 : 64'b01);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1 reset = 1'b1;
        tick();
        tick();
        chk("rst_ctrl", 64'({byte_ready, wr_en, busy, done, error}), 64'd0);
        chk("rst_addr_data", {wr_addr, wr_data}, 64'd0);
        reset = 1'b0;
        tick();
        chk("idle_ctrl", 64'({byte_ready, wr_en, busy, done, error}), 64'd0);

        // Two-word MIPS example, valid every cycle.
        words[0] = 32'h2008_0005;
        words[1] = 32'hAC08_0000;
        do_start();
        chk("hdr_ready", 64'({byte_ready, busy}), 64'b11);
        load(2, 1'b0, 1'b1, -1);
        chk("hold_data", {wr_addr, wr_data}, {32'h4, 32'hAC08_0000});

`ifdef LOADER_CHECKSUM_EN
        // Bad trailer: both words still written, then error.
        do_start();
        load(2, 1'b0, 1'b0, -1);
        chk("bad_ck_ready", 64'({byte_ready, busy}), 64'd0);
`endif

        // Same stream with byte_valid toggling every cycle.
        do_start();
        load(2, 1'b1, 1'b1, -1);

        // Zero-length and oversize headers.
        do_start();
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        chk("n0_err", 64'({error, done, busy, byte_ready}), 64'b1000);
        do_start();
        chk("err_cleared", 64'({error, busy}), 64'b01);
        send(8'h00, 1'b0);
        send(8'h41, 1'b0);
        chk("n65_err", 64'({error, done, busy, byte_ready}), 64'b1000);

        // Largest accepted count, random data.
        for (int i = 0; i < 64; i++) words[i] = $urandom;
        do_start();
        load(64, 1'b0, 1'b1, -1);
        chk("max_last_addr", 64'(wr_addr), 64'(BASE + 32'd252));

        // Reset after six data bytes.
        words[0] = 32'h2008_0005;
        words[1] = 32'hAC08_0000;
        exp_q.push_back({BASE, words[0]});
        do_start();
        send(8'h00, 1'b0);
        send(8'h02, 1'b0);
        send(8'h20, 1'b0); send(8'h08, 1'b0); send(8'h00, 1'b0); send(8'h05, 1'b0);
        send(8'hAC, 1'b0); send(8'h08, 1'b0);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("midrst_ctrl", 64'({byte_ready, wr_en, busy, done, error}), 64'd0);
        chk("midrst_addr_data", {wr_addr, wr_data}, 64'd0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("post_rst_idle", 64'({busy, done, error}), 64'd0);
        words[0] = 32'hDEAD_BEEF;
        do_start();
        load(1, 1'b0, 1'b1, -1);

        // Start while busy is ignored; start in DONE begins a new load.
        words[0] = 32'h1234_5678;
        words[1] = 32'h9ABC_DEF0;
        words[2] = 32'h0F0F_F0F0;
        do_start();
        load(3, 1'b0, 1'b1, 5);
        do_start();
        chk("restart_from_done", 64'({done, busy}), 64'b01);
        load(3, 1'b1, 1'b1, -1);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
